// File: rtl/vga_timing_controller.sv
// vga_timing_controller
//   640x480@60Hz VGA scan sequencer running from the 100 MHz board clock.
//   A one-cycle pixel enable (divide-by-DIV) steps the horizontal/vertical
//   counters. All scan outputs are registered and change in the same cycle as
//   x/y. A req/ack window opens once per frame at the start of vertical
//   blanking. If the window is still open at the next frame start, it is
//   reported as an overrun.
//   Optional feature macro: TEST_PATTERN_EN (8 vertical colour bars on rgb).
// Ports
//   CLK100MHZ   : system clock (sole clock)
//   reset       : synchronous, active-high reset
//   pix_tick    : one-cycle pixel enable, every DIV cycles
//   hsync/vsync : sync outputs, active level SYNC_POL
//   video_on    : high inside the visible area
//   x, y        : current scan position
//   line_start  : pulse when x becomes 0
//   frame_start : pulse when (x,y) becomes (0,0)
//   frame_req   : update window open
//   update_ack  : game logic finished its per-frame update
//   overrun     : pulse when the window closes without an ack
//   overrun_cnt : saturating overrun count
//   rgb         : test pattern colour (0 unless TEST_PATTERN_EN)
module vga_timing_controller #(
  parameter int unsigned DIV       = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  output logic        pix_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        line_start,
  output logic        frame_start,
  output logic        frame_req,
  input  logic        update_ack,
  output logic        overrun,
  output logic [7:0]  overrun_cnt,
  output logic [11:0] rgb
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned CNT_W    = 10;
  localparam int unsigned DIV_W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned HS_START = H_VISIBLE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  typedef enum logic {WIN_IDLE = 1'b0, WIN_OPEN = 1'b1} win_state_t;

  logic [DIV_W-1:0] div_cnt;
  logic             adv;
  logic [CNT_W-1:0] x_nxt;
  logic [CNT_W-1:0] y_nxt;
  logic             hs_act;
  logic             vs_act;
  logic             vis;
  logic             at_frame;
  logic             at_vblank;
  win_state_t       state;
  win_state_t       state_next;
  logic             overrun_set;

  // Counters and registered outputs step on the edge that moves div_cnt to
  // DIV-1, so pix_tick and the new position appear in the same cycle.
  assign adv = (div_cnt == DIV_W'(DIV - 2));

  // Pixel divider: 0..DIV-1
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_W'(DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Next scan position
  always_comb begin
    x_nxt = x + CNT_W'(1);
    y_nxt = y;
    if (x == CNT_W'(H_TOTAL - 1)) begin
      x_nxt = '0;
      y_nxt = (y == CNT_W'(V_TOTAL - 1)) ? '0 : y + CNT_W'(1);
    end
  end

  assign hs_act    = (x_nxt >= CNT_W'(HS_START)) && (x_nxt < CNT_W'(HS_END));
  assign vs_act    = (y_nxt >= CNT_W'(VS_START)) && (y_nxt < CNT_W'(VS_END));
  assign vis       = (x_nxt < CNT_W'(H_VISIBLE)) && (y_nxt < CNT_W'(V_VISIBLE));
  assign at_frame  = adv && (x_nxt == '0) && (y_nxt == '0);
  assign at_vblank = adv && (x_nxt == '0) && (y_nxt == CNT_W'(V_VISIBLE));

  // Scan counters and decoded timing outputs
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      x           <= CNT_W'(H_TOTAL - 1);
      y           <= CNT_W'(V_TOTAL - 1);
      pix_tick    <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= adv;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (adv) begin
        x           <= x_nxt;
        y           <= y_nxt;
        hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
        vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
        video_on    <= vis;
        line_start  <= (x_nxt == '0);
        frame_start <= at_frame;
      end
    end
  end

  // Update window state register
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state <= WIN_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Window next state; an ack in the frame-wrap cycle closes cleanly
  always_comb begin
    state_next  = state;
    overrun_set = 1'b0;
    case (state)
      WIN_IDLE: begin
        if (at_vblank) begin
          state_next = WIN_OPEN;
        end
      end
      WIN_OPEN: begin
        if (update_ack) begin
          state_next = WIN_IDLE;
        end else if (at_frame) begin
          state_next  = WIN_IDLE;
          overrun_set = 1'b1;
        end
      end
      default: state_next = WIN_IDLE;
    endcase
  end

  // Window outputs and saturating overrun counter
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      frame_req   <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      frame_req <= (state_next == WIN_OPEN);
      overrun   <= overrun_set;
      if (overrun_set && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

`ifdef TEST_PATTERN_EN
  localparam int unsigned BAR_W = 80;

  logic [2:0]  bar;
  logic [11:0] bar_rgb;

  assign bar = 3'(x_nxt / CNT_W'(BAR_W));

  // Bar colours, left to right
  always_comb begin
    bar_rgb = 12'h000;
    case (bar)
      3'd0:    bar_rgb = 12'hFFF;
      3'd1:    bar_rgb = 12'hFF0;
      3'd2:    bar_rgb = 12'h0FF;
      3'd3:    bar_rgb = 12'h0F0;
      3'd4:    bar_rgb = 12'hF0F;
      3'd5:    bar_rgb = 12'hF00;
      3'd6:    bar_rgb = 12'h00F;
      default: bar_rgb = 12'h000;
    endcase
  end

  // Colour register, blank outside the visible area
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      rgb <= 12'h000;
    end else if (adv) begin
      rgb <= vis ? bar_rgb : 12'h000;
    end
  end
`else
  assign rgb = 12'h000;
`endif

endmodule

// File: tb/tb_vga_timing_controller.sv
`timescale 1ns/1ps
module tb_vga_timing_controller;

  // Compact geometry for the frame-level instance
  localparam int S_DIV = 3;
  localparam int S_HV  = 16;
  localparam int S_HFP = 2;
  localparam int S_HS  = 4;
  localparam int S_HBP = 3;
  localparam int S_VV  = 12;
  localparam int S_VFP = 2;
  localparam int S_VS  = 2;
  localparam int S_VBP = 3;
  localparam bit S_POL = 1'b1;
  localparam int S_HT  = S_HV + S_HFP + S_HS + S_HBP;
  localparam int S_VT  = S_VV + S_VFP + S_VS + S_VBP;
  localparam int FRAME = S_HT * S_VT * S_DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Full-size instance (default parameters)
  logic        b_rst, b_tick, b_hs, b_vs, b_von, b_ls, b_fs, b_req, b_ack, b_ovr;
  logic [9:0]  b_x, b_y;
  logic [7:0]  b_cnt;
  logic [11:0] b_rgb;

  vga_timing_controller dut_b (
    .CLK100MHZ(clk), .reset(b_rst), .pix_tick(b_tick), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_von), .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs),
    .frame_req(b_req), .update_ack(b_ack), .overrun(b_ovr), .overrun_cnt(b_cnt),
    .rgb(b_rgb)
  );

  // Small-geometry instance, checked cycle by cycle against the model
  logic        s_rst, s_tick, s_hs, s_vs, s_von, s_ls, s_fs, s_req, s_ack, s_ovr;
  logic [9:0]  s_x, s_y;
  logic [7:0]  s_cnt;
  logic [11:0] s_rgb;

  vga_timing_controller #(
    .DIV(S_DIV), .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .SYNC_POL(S_POL)
  ) dut_s (
    .CLK100MHZ(clk), .reset(s_rst), .pix_tick(s_tick), .hsync(s_hs), .vsync(s_vs),
    .video_on(s_von), .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs),
    .frame_req(s_req), .update_ack(s_ack), .overrun(s_ovr), .overrun_cnt(s_cnt),
    .rgb(s_rgb)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       tick, hs, vs, von, ls, fs, req, ovr;
    logic [7:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  obs_t sb_act, sb_exp;

  int m_div, m_x, m_y, m_cnt;
  bit m_tick, m_ls, m_fs, m_open, m_over;

  function automatic void model_reset();
    m_div = 0; m_x = S_HT - 1; m_y = S_VT - 1; m_cnt = 0;
    m_tick = 0; m_ls = 0; m_fs = 0; m_open = 0; m_over = 0;
  endfunction

  function automatic void model_step(input bit ack);
    bit wrap, vstart;
    wrap = 0; vstart = 0;
    m_div  = (m_div + 1) % S_DIV;
    m_tick = (m_div == S_DIV - 1);
    m_ls = 0; m_fs = 0; m_over = 0;
    if (m_tick) begin
      m_x++;
      if (m_x == S_HT) begin
        m_x = 0;
        m_y++;
        if (m_y == S_VT) m_y = 0;
      end
      m_ls   = (m_x == 0);
      m_fs   = (m_x == 0) && (m_y == 0);
      wrap   = m_fs;
      vstart = (m_x == 0) && (m_y == S_VV);
    end
    if (m_open) begin
      if (ack) m_open = 0;
      else if (wrap) begin
        m_open = 0;
        m_over = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end else if (vstart) begin
      m_open = 1;
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.x    = 10'(m_x);
    o.y    = 10'(m_y);
    o.tick = m_tick;
    o.hs   = (m_x >= S_HV + S_HFP && m_x < S_HV + S_HFP + S_HS) ? S_POL : ~S_POL;
    o.vs   = (m_y >= S_VV + S_VFP && m_y < S_VV + S_VFP + S_VS) ? S_POL : ~S_POL;
    o.von  = (m_x < S_HV) && (m_y < S_VV);
    o.ls   = m_ls;
    o.fs   = m_fs;
    o.req  = m_open;
    o.ovr  = m_over;
    o.cnt  = 8'(m_cnt);
    return o;
  endfunction

  // Scoreboard: model expectation pushed at each edge, popped against the DUT
  initial forever begin
    @(posedge clk);
    if (s_rst) model_reset();
    else model_step(s_ack);
    exp_q.push_back(model_obs());
    #1;
    sb_act = '{x: s_x, y: s_y, tick: s_tick, hs: s_hs, vs: s_vs, von: s_von,
               ls: s_ls, fs: s_fs, req: s_req, ovr: s_ovr, cnt: s_cnt};
    sb_exp = exp_q.pop_front();
    n_checks++;
    if (sb_act !== sb_exp) begin
      n_fail++;
      $display("FAIL scoreboard t=%0t got %h expected %h", $time, sb_act, sb_exp);
    end
  end

  task automatic wait_s(input int tx, input int ty, input string tag);
    int n;
    bit hit;
    n = 0; hit = 0;
    while (!hit && n < 2 * FRAME) begin
      @(posedge clk); #1; n++;
      hit = s_tick && (s_x == 10'(tx)) && (s_y == 10'(ty));
    end
    if (!hit) begin
      n_checks++; n_fail++;
      $display("FAIL wait_%s: got no tick at (%0d,%0d) within %0d cycles", tag, tx, ty, n);
    end
  endtask

  task automatic test_reset();
    b_rst = 1; s_rst = 1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({b_x, b_y, b_tick, b_hs, b_vs, b_von, b_ls, b_fs, b_req, b_ovr, b_cnt, b_rgb} !==
        {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'h000}) begin
      n_fail++;
      $display("FAIL reset_state: got x=%0d y=%0d tick=%b hs=%b vs=%b von=%b cnt=%0d rgb=%h expected 799/524 0 1 1 0 0 000",
               b_x, b_y, b_tick, b_hs, b_vs, b_von, b_cnt, b_rgb);
    end
    b_rst = 0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (k < 3) begin
        if ({b_tick, b_x} !== {1'b0, 10'd799}) begin
          n_fail++;
          $display("FAIL pre_tick_%0d: got tick=%b x=%0d expected 0 799", k, b_tick, b_x);
        end
      end else begin
        if ({b_tick, b_x, b_y, b_fs, b_ls, b_von, b_hs} !==
            {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1}) begin
          n_fail++;
          $display("FAIL first_tick: got tick=%b x=%0d y=%0d fs=%b ls=%b von=%b expected 1 0 0 1 1 1",
                   b_tick, b_x, b_y, b_fs, b_ls, b_von);
        end
      end
    end
  endtask

  task automatic test_line();
    int low, first, last, ticks, ls, von;
    low = 0; first = -1; last = -1; ticks = 0; ls = 0; von = 0;
    for (int i = 0; i < 800 * 4; i++) begin
      @(posedge clk); #1;
      if (!b_hs) begin
        low++;
        if (first < 0) first = int'(b_x);
        last = int'(b_x);
      end
      if (b_tick) ticks++;
      if (b_ls) ls++;
      if (b_von) von++;
    end
    n_checks++;
    if (low != 384 || first != 656 || last != 751) begin
      n_fail++;
      $display("FAIL hsync_window: got %0d clocks x=%0d..%0d expected 384 clocks x=656..751", low, first, last);
    end
    n_checks++;
    if (ticks != 800 || ls != 1 || von != 2560) begin
      n_fail++;
      $display("FAIL line_counts: got ticks=%0d ls=%0d von=%0d expected 800 1 2560", ticks, ls, von);
    end
    n_checks++;
    if ({b_x, b_y, b_ls, b_fs} !== {10'd0, 10'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL line_wrap: got x=%0d y=%0d ls=%b fs=%b expected 0 1 1 0", b_x, b_y, b_ls, b_fs);
    end
  endtask

  task automatic test_frame();
    int n, vclk, vmin, vmax;
    s_rst = 0;
    wait_s(0, 0, "first_frame");
    n = 0; vclk = 0; vmin = 1000; vmax = -1;
    do begin
      @(posedge clk); #1; n++;
      if (s_vs == S_POL) begin
        vclk++;
        if (int'(s_y) < vmin) vmin = int'(s_y);
        if (int'(s_y) > vmax) vmax = int'(s_y);
      end
    end while (!s_fs && n < 2 * FRAME);
    n_checks++;
    if (n != FRAME) begin
      n_fail++;
      $display("FAIL frame_period: got %0d clocks expected %0d", n, FRAME);
    end
    n_checks++;
    if (vclk != S_VS * S_HT * S_DIV || vmin != S_VV + S_VFP || vmax != S_VV + S_VFP + S_VS - 1) begin
      n_fail++;
      $display("FAIL vsync_window: got %0d clocks lines %0d..%0d expected %0d clocks lines %0d..%0d",
               vclk, vmin, vmax, S_VS * S_HT * S_DIV, S_VV + S_VFP, S_VV + S_VFP + S_VS - 1);
    end
    n_checks++;
    if ({s_ovr, s_cnt, s_req} !== {1'b1, 8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL first_overrun: got ovr=%b cnt=%0d req=%b expected 1 1 0", s_ovr, s_cnt, s_req);
    end
  endtask

  task automatic test_window_ack();
    logic [7:0] cnt0;
    wait_s(0, 2, "idle_line");
    s_ack = 1;
    @(posedge clk); #1;
    s_ack = 0;
    n_checks++;
    if (s_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ack: got req=%b expected 0", s_req);
    end
    wait_s(0, S_VV, "vblank_open");
    n_checks++;
    if ({s_req, s_ovr} !== 2'b10) begin
      n_fail++;
      $display("FAIL window_open: got req=%b ovr=%b expected 1 0", s_req, s_ovr);
    end
    cnt0 = s_cnt;
    wait_s(0, S_VV + 4, "ack_line");
    s_ack = 1;
    @(posedge clk); #1;
    s_ack = 0;
    n_checks++;
    if ({s_req, s_ovr, s_cnt} !== {1'b0, 1'b0, cnt0}) begin
      n_fail++;
      $display("FAIL ack_close: got req=%b ovr=%b cnt=%0d expected 0 0 %0d", s_req, s_ovr, s_cnt, cnt0);
    end
    wait_s(0, 0, "acked_wrap");
    n_checks++;
    if ({s_ovr, s_cnt, s_fs} !== {1'b0, cnt0, 1'b1}) begin
      n_fail++;
      $display("FAIL acked_wrap: got ovr=%b cnt=%0d fs=%b expected 0 %0d 1", s_ovr, s_cnt, s_fs, cnt0);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] cnt0;
    cnt0 = s_cnt;
    for (int f = 0; f < 3; f++) begin
      wait_s(0, S_VV, "ovr_open");
      n_checks++;
      if (s_req !== 1'b1) begin
        n_fail++;
        $display("FAIL ovr_open_%0d: got req=%b expected 1", f, s_req);
      end
      wait_s(0, 0, "ovr_wrap");
      n_checks++;
      if ({s_ovr, s_req, s_fs} !== 3'b101) begin
        n_fail++;
        $display("FAIL ovr_pulse_%0d: got ovr=%b req=%b fs=%b expected 1 0 1", f, s_ovr, s_req, s_fs);
      end
    end
    n_checks++;
    if (s_cnt !== 8'(cnt0 + 8'd3)) begin
      n_fail++;
      $display("FAIL ovr_count: got %0d expected %0d", s_cnt, cnt0 + 8'd3);
    end
    @(posedge clk); #1;
    n_checks++;
    if (s_ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_width: got ovr=%b one cycle later expected 0", s_ovr);
    end
  endtask

  task automatic test_ack_on_wrap();
    logic [7:0] cnt0;
    cnt0 = s_cnt;
    wait_s(S_HT - 1, S_VT - 1, "last_pixel");
    n_checks++;
    if (s_req !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_window: got req=%b expected 1", s_req);
    end
    repeat (S_DIV - 1) @(posedge clk);
    #1;
    s_ack = 1;
    @(posedge clk); #1;
    s_ack = 0;
    n_checks++;
    if ({s_x, s_y, s_fs, s_ovr, s_req, s_cnt} !== {10'd0, 10'd0, 1'b1, 1'b0, 1'b0, cnt0}) begin
      n_fail++;
      $display("FAIL ack_on_wrap: got x=%0d y=%0d fs=%b ovr=%b req=%b cnt=%0d expected 0 0 1 0 0 %0d",
               s_x, s_y, s_fs, s_ovr, s_req, s_cnt, cnt0);
    end
  endtask

  task automatic test_mid_reset();
    wait_s(0, S_VV + 2, "open_line");
    n_checks++;
    if (s_req !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_req: got %b expected 1", s_req);
    end
    s_rst = 1;
    @(posedge clk); #1;
    s_rst = 0;
    n_checks++;
    if ({s_x, s_y, s_req, s_ovr, s_cnt, s_tick, s_vs, s_hs} !==
        {10'(S_HT - 1), 10'(S_VT - 1), 1'b0, 1'b0, 8'd0, 1'b0, ~S_POL, ~S_POL}) begin
      n_fail++;
      $display("FAIL mid_reset: got x=%0d y=%0d req=%b ovr=%b cnt=%0d tick=%b expected %0d %0d 0 0 0 0",
               s_x, s_y, s_req, s_ovr, s_cnt, s_tick, S_HT - 1, S_VT - 1);
    end
    for (int k = 1; k < S_DIV; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (k < S_DIV - 1) begin
        if (s_tick !== 1'b0) begin
          n_fail++;
          $display("FAIL resume_wait_%0d: got tick=%b expected 0", k, s_tick);
        end
      end else if ({s_tick, s_x, s_y, s_fs, s_ovr} !== {1'b1, 10'd0, 10'd0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL resume: got tick=%b x=%0d y=%0d fs=%b ovr=%b expected 1 0 0 1 0",
                 s_tick, s_x, s_y, s_fs, s_ovr);
      end
    end
  endtask

  initial begin
    b_rst = 1; s_rst = 1; b_ack = 0; s_ack = 0;
    test_reset();
    test_line();
    test_frame();
    test_window_ack();
    test_overrun();
    test_ack_on_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
